// File: rtl/toggle_request_gen_pkg.sv
// Shared state encoding and counter-sizing helper for the button conditioning
// and prescaler/counter blocks.
package toggle_request_gen_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int          r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/toggle_request_gen_sync_2ff.sv
// Two-flop level synchroniser for raw asynchronous inputs; both flops reset
// asynchronously to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      // second stage: metastability settled
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/toggle_request_gen.sv
// Push-button conditioner: synchronise, debounce, and emit one-cycle toggle
// requests per accepted press, with optional hold-to-repeat.
module toggle_request_gen
  import toggle_request_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 500000,
  parameter int REPEAT_EN            = 0,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic t,
  output logic pressed
);

  localparam int MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ?
                          DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
  localparam int MAX_P  = (MAX_DR > REPEAT_PERIOD_CYCLES) ? MAX_DR : REPEAT_PERIOD_CYCLES;
  localparam int CNT_W  = clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD_CYCLES - 1);

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rpt_armed;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (s)
  );

  // rpt_armed selects the period compare once the initial repeat delay has elapsed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rpt_armed <= 1'b0;
      t         <= 1'b0;
      pressed   <= 1'b0;
    end else begin
      t <= 1'b0;
      case (state)
        IDLE: begin
          pressed   <= 1'b0;
          cnt       <= '0;
          rpt_armed <= 1'b0;
          if (s) state <= PRESS_CHK;
        end
        PRESS_CHK: begin
          pressed <= 1'b0;
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            rpt_armed <= 1'b0;
            t         <= 1'b1;
            pressed   <= 1'b1;
          end else begin
            cnt <= cnt_inc(cnt);
          end
        end
        HELD: begin
          pressed <= 1'b1;
          if (!s) begin
            state <= REL_CHK;
            cnt   <= '0;
          end else if (REPEAT_EN != 0) begin
            if (cnt == (rpt_armed ? PER_LAST : DLY_LAST)) begin
              t         <= 1'b1;
              cnt       <= '0;
              rpt_armed <= 1'b1;
            end else begin
              cnt <= cnt_inc(cnt);
            end
          end
        end
        REL_CHK: begin
          pressed <= 1'b1;
          if (s) begin
            // bounce back to held restarts the repeat delay, no new initial pulse
            state     <= HELD;
            cnt       <= '0;
            rpt_armed <= 1'b0;
          end else if (cnt == DB_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            pressed <= 1'b0;
          end else begin
            cnt <= cnt_inc(cnt);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          rpt_armed <= 1'b0;
          pressed   <= 1'b0;
        end
      endcase
    end
  end

endmodule
